// File: rtl/rv32m_seq_divider.sv
// -----------------------------------------------------------------------------
// rv32m_seq_divider
// Multi-cycle RV32M divide/remainder unit (DIV, DIVU, REM, REMU).
// The unit runs a radix-2 restoring division on operand magnitudes, one quotient
// bit per clock. It then applies the RISC-V sign rules and holds the result
// until writeback takes it.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   request valid
//   in_ready   unit can accept a request (high only in IDLE)
//   op         funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   rs1        dividend
//   rs2        divisor
//   flush      synchronous abort; drops any request in flight
//   out_valid  result valid
//   out_ready  writeback accepts the result
//   result     quotient or remainder, selected by op
//   busy       high in any state other than IDLE
// -----------------------------------------------------------------------------
module rv32m_seq_divider #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [XLEN-1:0]   rem_reg;
    logic [XLEN-1:0]   quo_reg;
    logic [XLEN-1:0]   dvs_reg;
    logic [XLEN-1:0]   result_reg;
    logic              neg_q_reg;
    logic              neg_r_reg;
    logic              sel_rem_reg;
    logic              out_valid_reg;

    // Request decode, evaluated on the raw inputs at the accept edge.
    logic              accept;
    logic              rs1_neg;
    logic              rs2_neg;
    logic [XLEN-1:0]   rs1_mag;
    logic [XLEN-1:0]   rs2_mag;
    logic              div_zero;
    logic              sgn_ovf;
    logic [XLEN-1:0]   special_res;

    assign accept   = in_valid && (state_reg == IDLE) && !flush;
    assign rs1_neg  = !op[0] && rs1[XLEN-1];
    assign rs2_neg  = !op[0] && rs2[XLEN-1];
    assign rs1_mag  = rs1_neg ? -rs1 : rs1;
    assign rs2_mag  = rs2_neg ? -rs2 : rs2;
    assign div_zero = (rs2 == '0);
    assign sgn_ovf  = !op[0] && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);

    // Divide by zero is tested first: quotient all ones, remainder = dividend.
    // Signed overflow: quotient = most negative value, remainder = 0.
    always_comb begin
        special_res = '0;
        if (div_zero)
            special_res = op[1] ? rs1 : '1;
        else
            special_res = op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end

    // One restoring step. After the shift, the partial remainder can reach
    // 2*divisor-1, which needs XLEN+1 bits. The subtraction is carried one bit
    // wider again, so its top bit is a clean borrow/sign flag.
    logic [XLEN:0]     rem_sh;
    logic [XLEN+1:0]   trial;
    logic              trial_ok;

    assign rem_sh   = {rem_reg, quo_reg[XLEN-1]};
    assign trial    = {1'b0, rem_sh} - {2'b00, dvs_reg};
    assign trial_ok = !trial[XLEN+1];

    // Sign fix-up applied in the FIX state.
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;

    assign quo_fix = neg_q_reg ? -quo_reg : quo_reg;
    assign rem_fix = neg_r_reg ? -rem_reg : rem_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            rem_reg       <= '0;
            quo_reg       <= '0;
            dvs_reg       <= '0;
            result_reg    <= '0;
            neg_q_reg     <= 1'b0;
            neg_r_reg     <= 1'b0;
            sel_rem_reg   <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        sel_rem_reg <= op[1];
                        if (div_zero || sgn_ovf) begin
                            result_reg    <= special_res;
                            out_valid_reg <= 1'b1;
                            state_reg     <= DONE;
                        end else begin
                            // The dividend magnitude sits in quo_reg and is
                            // shifted out MSB-first into the remainder.
                            rem_reg   <= '0;
                            quo_reg   <= rs1_mag;
                            dvs_reg   <= rs2_mag;
                            neg_q_reg <= rs1_neg ^ rs2_neg;
                            neg_r_reg <= rs1_neg;
                            cnt_reg   <= '0;
                            state_reg <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (flush) begin
                        state_reg <= IDLE;
                    end else begin
                        if (trial_ok) begin
                            rem_reg <= trial[XLEN-1:0];
                            quo_reg <= {quo_reg[XLEN-2:0], 1'b1};
                        end else begin
                            rem_reg <= rem_sh[XLEN-1:0];
                            quo_reg <= {quo_reg[XLEN-2:0], 1'b0};
                        end
                        cnt_reg <= cnt_reg + 1'b1;
                        if (cnt_reg == CNT_W'(XLEN-1))
                            state_reg <= FIX;
                    end
                end
                FIX: begin
                    if (flush) begin
                        state_reg <= IDLE;
                    end else begin
                        result_reg    <= sel_rem_reg ? rem_fix : quo_fix;
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end
                end
                DONE: begin
                    // A flush drops the result even if writeback accepts it
                    // in the same cycle. result keeps its last value.
                    if (flush || out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign busy      = (state_reg != IDLE);
    assign out_valid = out_valid_reg;
    assign result    = result_reg;

endmodule

// File: tb/tb_rv32m_seq_divider.sv
module tb_rv32m_seq_divider;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  op = 2'b00;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    localparam int NORM_LAT = 33;

    rv32m_seq_divider #(.XLEN(32), .CNT_W(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .rs1       (rs1),
        .rs2       (rs2),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference model: plain RISC-V M-extension arithmetic.
    function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = int'(a);
        sb = int'(b);
        if (b == 32'd0)
            return o[1] ? a : 32'hFFFF_FFFF;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return o[1] ? 32'd0 : 32'h8000_0000;
        case (o)
            2'b00:   return 32'(sa / sb);
            2'b01:   return a / b;
            2'b10:   return 32'(sa % sb);
            default: return a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))
            return 0;
        return NORM_LAT;
    endfunction

    // Present a request; it is accepted at the next rising edge. Return #1 after that edge.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        op = o; rs1 = a; rs2 = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Count rising edges after the accept edge until out_valid is seen (bounded).
    task automatic wait_valid(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    // Full transaction with result and latency check.
    task automatic run_check(input string name, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        int lat;
        logic [31:0] exp_r;
        int exp_lat;
        exp_r = ref_result(o, a, b);
        exp_lat = ref_latency(o, a, b);
        issue(o, a, b);
        rs1 = $urandom; rs2 = $urandom; op = 2'($urandom);
        wait_valid(lat);
        n_cmp++;
        if (result !== exp_r || lat != exp_lat || out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL %s op=%0d a=%h b=%h: got result=%h lat=%0d valid=%b, expected result=%h lat=%0d valid=1",
                     name, o, a, b, result, lat, out_valid, exp_r, exp_lat);
        end else begin
            $display("ok   %s op=%0d a=%h b=%h result=%h lat=%0d", name, o, a, b, result, lat);
        end
        handshake();
    endtask

    task automatic test_reset();
        #2;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || result !== 32'd0) begin
            n_bad++;
            $display("FAIL reset: got in_ready=%b out_valid=%b busy=%b result=%h, expected 1 0 0 00000000",
                     in_ready, out_valid, busy, result);
        end else $display("ok   reset state");
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        run_check("div_10_3",      2'b00, 32'd10, 32'd3);
        run_check("rem_m10_3",     2'b10, -32'sd10, 32'd3);
        run_check("div_10_m3",     2'b00, 32'd10, -32'sd3);
        run_check("rem_m10_m3",    2'b10, -32'sd10, -32'sd3);
        run_check("divu_big_3",    2'b01, 32'hFFFF_FFF6, 32'd3);
        run_check("remu_big_7",    2'b11, 32'hFFFF_FFFF, 32'd7);
        run_check("div_min_1",     2'b00, 32'h8000_0000, 32'd1);
        run_check("divu_small_big",2'b01, 32'd5, 32'hFFFF_FFFF);
    endtask

    task automatic test_div_zero();
        run_check("div_7_0",  2'b00, 32'd7, 32'd0);
        run_check("divu_7_0", 2'b01, 32'd7, 32'd0);
        run_check("rem_7_0",  2'b10, 32'd7, 32'd0);
        run_check("remu_7_0", 2'b11, 32'd7, 32'd0);
        run_check("rem_neg_0",2'b10, 32'h8000_0001, 32'd0);
    endtask

    task automatic test_overflow();
        run_check("div_ovf",   2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
        run_check("rem_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        run_check("divu_noovf",2'b01, 32'h8000_0000, 32'hFFFF_FFFF);
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: b = 32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            a = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
            run_check("random", 2'($urandom), a, b);
        end
    endtask

    // Hold off writeback for 10 cycles while scrambling inputs; result must stay put.
    task automatic test_backpressure();
        int lat;
        int unstable;
        logic [31:0] exp_r;
        exp_r = ref_result(2'b00, 32'd1000, 32'd7);
        issue(2'b00, 32'd1000, 32'd7);
        wait_valid(lat);
        unstable = 0;
        for (int i = 0; i < 10; i++) begin
            rs1 = $urandom; rs2 = $urandom; in_valid = 1'b1;
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || result !== exp_r || in_ready !== 1'b0) unstable++;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (unstable != 0 || lat != NORM_LAT) begin
            n_bad++;
            $display("FAIL backpressure: got %0d unstable cycles lat=%0d result=%h, expected 0 unstable lat=%0d result=%h",
                     unstable, lat, result, NORM_LAT, exp_r);
        end else $display("ok   backpressure result=%h held 10 cycles", result);
        handshake();
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || result !== exp_r) begin
            n_bad++;
            $display("FAIL after_handshake: got out_valid=%b busy=%b result=%h, expected 0 0 %h",
                     out_valid, busy, result, exp_r);
        end else $display("ok   handshake returns to idle, result held");
    endtask

    // Second request held valid through the handshake edge: accepted on the next edge.
    task automatic test_back_to_back();
        int lat;
        logic [31:0] exp_r;
        issue(2'b01, 32'd99, 32'd4);
        wait_valid(lat);
        exp_r = ref_result(2'b11, 32'd99, 32'd4);
        op = 2'b11; rs1 = 32'd99; rs2 = 32'd4; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_gap: got in_ready=%b out_valid=%b busy=%b, expected 1 0 0", in_ready, out_valid, busy);
        end else $display("ok   b2b idle gap after handshake");
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_accept: got busy=%b in_ready=%b, expected 1 0", busy, in_ready);
        end else $display("ok   b2b second request accepted");
        wait_valid(lat);
        n_cmp++;
        if (result !== exp_r || lat != NORM_LAT) begin
            n_bad++;
            $display("FAIL b2b_result: got result=%h lat=%0d, expected %h lat=%0d", result, lat, exp_r, NORM_LAT);
        end else $display("ok   b2b result=%h lat=%0d", result, lat);
        handshake();
    endtask

    task automatic test_flush();
        int seen;
        issue(2'b00, 32'd123456, 32'd789);
        repeat (15) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL flush_idle: got busy=%b out_valid=%b in_ready=%b, expected 0 0 1", busy, out_valid, in_ready);
        end else $display("ok   flush returns to idle");
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_bad++;
            $display("FAIL flush_no_result: got %0d valid cycles, expected 0", seen);
        end else $display("ok   flushed request produced no result");
        // A flush in DONE together with out_ready drops the result.
        issue(2'b00, 32'd7, 32'd0);
        flush = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; out_ready = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_done: got busy=%b out_valid=%b, expected 0 0", busy, out_valid);
        end else $display("ok   flush in done drops result");
        // A flush in IDLE blocks acceptance.
        op = 2'b00; rs1 = 32'd9; rs2 = 32'd3; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_idle_block: got busy=%b, expected 0", busy);
        end else $display("ok   flush blocks acceptance in idle");
        run_check("divu_100_7", 2'b01, 32'd100, 32'd7);
    endtask

    task automatic test_async_reset();
        issue(2'b00, 32'd5000, 32'd3);
        repeat (20) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'd0) begin
            n_bad++;
            $display("FAIL async_reset: got busy=%b out_valid=%b in_ready=%b result=%h, expected 0 0 1 00000000",
                     busy, out_valid, in_ready, result);
        end else $display("ok   async reset mid-calc");
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        run_check("div_0_3", 2'b00, 32'd0, 32'd3);
        run_check("rem_7_7", 2'b10, 32'd7, 32'd7);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_div_zero();
        test_overflow();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
